// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier built around an external
// WIDTH-bit ripple-carry adder. One partial-product step per cycle; the
// product appears WIDTH edges after a start is accepted, with a one-cycle
// done pulse. The adder is combinational and lives outside this block.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_carry,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;     // multiplicand
  logic [WIDTH-1:0]   ph_q, ph_d;   // upper partial product
  logic [WIDTH-1:0]   pl_q, pl_d;   // multiplier bits shifting out, product low bits shifting in
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // State and datapath registers; synchronous reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= {WIDTH{1'b0}};
      ph_q      <= {WIDTH{1'b0}};
      pl_q      <= {WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      ph_q      <= ph_d;
      pl_q      <= pl_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update: load on accept, one shift-add step per RUN cycle
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    ph_d      = ph_q;
    pl_d      = pl_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a_in;
          pl_d    = b_in;
          ph_d    = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Carry-out becomes the new MSB of the upper half; sum LSB moves into the low half
        ph_d  = {add_carry, add_sum[WIDTH-1:1]};
        pl_d  = {add_sum[0], pl_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          product_d = {add_carry, add_sum[WIDTH-1:1], add_sum[0], pl_q[WIDTH-1:1]};
          state_d   = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; adder operands are zero outside RUN
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    add_a = {WIDTH{1'b0}};
    add_b = {WIDTH{1'b0}};
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_RUN: begin
        add_a = ph_q;
        if (pl_q[0]) begin
          add_b = m_q;
        end else begin
          add_b = {WIDTH{1'b0}};
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign product = product_q;

endmodule
